mem_loader: RTL and testbench

- Write-side companion to the dual-port instruction/data memories (12-bit word address, 32-bit data, byte write enables).
- Accepts a byte stream over a ready/valid handshake, typically from the UART receiver, and packs it little-endian into 32-bit words.
- Writes each word to consecutive word addresses starting at a programmed base address.
- Used to load programs into memory that the CPU later reads back through the other port.

---
 rtl/mem_loader_pkg.sv | 14 +
 rtl/mem_loader_byte_packer.sv | 56 +++++
 rtl/mem_loader.sv | 113 +++++++++++
 tb/tb_mem_loader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared constants for the byte-stream memory loader.
package mem_loader_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRecv  = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [3:0]  MEM_WE_ALL = 4'hF;

endpackage

// File: rtl/mem_loader_byte_packer.sv
// Little-endian byte-to-word assembler with a running modulo-256 byte sum.
module mem_loader_byte_packer
    import mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        clear,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_full,
    output logic [7:0]  sum
);

    localparam int unsigned IdxW = $clog2(WORD_BYTES);

    logic [IdxW-1:0] idx_q, idx_d;
    logic [31:0]     word_q, word_d;
    logic [7:0]      sum_q, sum_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        sum_d  = sum_q;
        if (clear) begin
            // The assembly register is fully overwritten before its next use.
            idx_d = '0;
            sum_d = '0;
        end else if (push) begin
            for (int i = 0; i < int'(WORD_BYTES); i++) begin
                if (idx_q == IdxW'(i)) begin
                    word_d[8*i +: 8] = in_byte;
                end
            end
            idx_d = idx_q + IdxW'(1);
            sum_d = sum_q + in_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            word_q <= '0;
            sum_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
            sum_q  <= sum_d;
        end
    end

    assign word      = word_q;
    assign word_full = (idx_q == IdxW'(WORD_BYTES - 1));
    assign sum       = sum_q;

endmodule

// File: rtl/mem_loader.sv
// Loads a ready/valid byte stream into consecutive 32-bit memory words from a base address.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned COUNT_WIDTH = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   mem_en,
    output logic [3:0]             mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [31:0]            mem_din,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             checksum
);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;

    logic        pack_push;
    logic        pack_clear;
    logic [31:0] pack_word;
    logic        pack_full;
    logic [7:0]  pack_sum;

    mem_loader_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .push      (pack_push),
        .clear     (pack_clear),
        .in_byte   (in_data),
        .word      (pack_word),
        .word_full (pack_full),
        .sum       (pack_sum)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        pack_push   = 1'b0;
        pack_clear  = 1'b0;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 4'h0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = word_count;
                    pack_clear  = 1'b1;
                    state_d     = (word_count == '0) ? StDone : StRecv;
                end
            end
            StRecv: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    pack_push = 1'b1;
                    if (pack_full) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                busy        = 1'b1;
                mem_en      = 1'b1;
                mem_we      = MEM_WE_ALL;
                // Address wraps naturally at the top of the memory.
                addr_d      = addr_q + ADDR_WIDTH'(1);
                remaining_d = remaining_q - COUNT_WIDTH'(1);
                state_d     = (remaining_q == COUNT_WIDTH'(1)) ? StDone : StRecv;
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_din  = pack_word;
    assign checksum = pack_sum;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed table, reset abort and randomized loads.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] word_count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_din;
    logic        busy;
    logic        done;
    logic [7:0]  checksum;

    mem_loader #(
        .ADDR_WIDTH  (12),
        .COUNT_WIDTH (13)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed write-port activity and done pulses.
    logic [11:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_we[$];
    logic        wr_rdy[$];
    int          wr_cyc[$];
    int          done_cyc[$];
    int          ready_cnt = 0;

    always @(negedge clk) begin
        if (mem_en) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_din);
            wr_we.push_back(mem_we);
            wr_rdy.push_back(in_ready);
            wr_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (in_ready) ready_cnt = ready_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_mem_en"},   32'(mem_en),   32'd0);
        chk({tag, "_mem_we"},   32'(mem_we),   32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_din"},  mem_din,       32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_checksum"}, 32'(checksum), 32'd0);
    endtask

    // gap: 0 = always valid, 1 = valid every other cycle, 2 = random.
    // abort_after < total bytes resets the DUT after that many accepted bytes.
    task automatic run_load(input logic [11:0] base, input int count, input logic [7:0] bq[$],
                            input int gap, input bit spur, input int abort_after,
                            output logic [31:0] first_word, output logic [7:0] dut_sum);
        int          wbase;
        int          dbase;
        int          rbase;
        int          start_cyc;
        int          n;
        int          idx;
        int          budget;
        int          limit;
        int          nw;
        bit          tog;
        bit          v;
        logic [7:0]  msum;
        logic [31:0] mw;
        logic [11:0] ma;

        n     = bq.size();
        limit = (abort_after < n) ? abort_after : n;
        msum  = 8'h00;
        for (int i = 0; i < n; i++) msum = msum + bq[i];
        first_word = 32'hDEAD_BEEF;

        @(negedge clk);
        wbase      = wr_addr.size();
        dbase      = done_cyc.size();
        rbase      = ready_cnt;
        start_cyc  = cyc;
        start      = 1'b1;
        base_addr  = base;
        word_count = 13'(count);
        in_valid   = 1'b0;
        @(negedge clk);
        start      = 1'b0;
        base_addr  = ~base;
        word_count = 13'h1FFF;

        idx    = 0;
        tog    = 1'b1;
        budget = 12 * n + 20;
        while (idx < limit && budget > 0) begin
            if (gap == 0)      v = 1'b1;
            else if (gap == 1) v = tog;
            else               v = 1'($urandom_range(0, 1));
            tog      = ~tog;
            in_valid = v;
            in_data  = bq[idx];
            if (spur && idx == 2) begin
                start      = 1'b1;
                base_addr  = 12'h3AA;
                word_count = 13'd5;
            end else begin
                start = 1'b0;
            end
            if (v && in_ready) idx++;
            @(negedge clk);
            budget--;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("feed_complete", 32'(idx), 32'(limit));

        if (limit < n) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk_reset_outputs("abort");
            repeat (12) @(negedge clk);
            chk("abort_write_count", 32'(wr_addr.size() - wbase), 32'(limit / 4));
            chk("abort_no_done", 32'(done_cyc.size() - dbase), 32'd0);
            if (wr_addr.size() > wbase) begin
                first_word = wr_data[wbase];
                chk("abort_w0_addr", 32'(wr_addr[wbase]), 32'(base));
            end
            dut_sum = checksum;
            return;
        end

        budget = 30;
        while (!done && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("done_seen", 32'(done), 32'd1);
        // A start and a byte offered during DONE must both be ignored.
        start      = 1'b1;
        base_addr  = 12'h077;
        word_count = 13'd1;
        in_valid   = 1'b1;
        in_data    = 8'hEE;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("ready_after_done", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("start_in_done_ignored", 32'(busy), 32'd0);
        chk("checksum", 32'(checksum), 32'(msum));
        dut_sum = checksum;

        nw = wr_addr.size() - wbase;
        chk("write_count", 32'(nw), 32'(count));
        for (int k = 0; k < count && k < nw; k++) begin
            ma = base + 12'(k);
            mw = {bq[4*k+3], bq[4*k+2], bq[4*k+1], bq[4*k]};
            chk($sformatf("w%0d_addr", k), 32'(wr_addr[wbase+k]), 32'(ma));
            chk($sformatf("w%0d_data", k), wr_data[wbase+k], mw);
            chk($sformatf("w%0d_we", k), 32'(wr_we[wbase+k]), 32'hF);
            chk($sformatf("w%0d_ready_low", k), 32'(wr_rdy[wbase+k]), 32'd0);
        end
        if (nw > 0) first_word = wr_data[wbase];
        chk("done_pulses", 32'(done_cyc.size() - dbase), 32'd1);
        if (done_cyc.size() > dbase) begin
            if (count > 0 && nw > 0) begin
                chk("done_after_last_write", 32'(done_cyc[dbase]), 32'(wr_cyc[wr_cyc.size()-1] + 1));
            end else if (count == 0) begin
                chk("zero_done_latency", 32'(done_cyc[dbase]), 32'(start_cyc + 1));
                chk("zero_ready_never", 32'(ready_cnt - rbase), 32'd0);
            end
        end
    endtask

    typedef struct {
        logic [11:0] base;
        int          count;
        int          gap;
        bit          spur;
        logic [7:0]  seed;
        logic [7:0]  step;
        logic [31:0] exp_w0;
        logic [7:0]  exp_sum;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [7:0]  bq[$];
        logic [7:0]  b;
        logic [31:0] w0;
        logic [7:0]  s;
        int          cnt;
        logic [11:0] rb;

        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        in_data    = '0;
        in_valid   = 1'b0;

        vecs[0] = '{12'h010, 1, 0, 1'b0, 8'h78, 8'hDE, 32'h1234_5678, 8'h14};
        vecs[1] = '{12'h100, 3, 1, 1'b1, 8'h01, 8'h01, 32'h0403_0201, 8'h4E};
        vecs[2] = '{12'hFFF, 2, 0, 1'b0, 8'hA0, 8'h11, 32'hD3C2_B1A0, 8'hDC};
        vecs[3] = '{12'h055, 0, 0, 1'b0, 8'h00, 8'h00, 32'hDEAD_BEEF, 8'h00};

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        // Bytes offered in IDLE must not be taken.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        @(negedge clk);
        chk("idle_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("idle_checksum", 32'(checksum), 32'd0);
        in_valid = 1'b0;

        for (int t = 0; t < 4; t++) begin
            bq.delete();
            b = vecs[t].seed;
            for (int i = 0; i < 4 * vecs[t].count; i++) begin
                bq.push_back(b);
                b = b + vecs[t].step;
            end
            run_load(vecs[t].base, vecs[t].count, bq, vecs[t].gap, vecs[t].spur, 1 << 30, w0, s);
            if (vecs[t].count > 0) chk($sformatf("vec%0d_word0", t), w0, vecs[t].exp_w0);
            chk($sformatf("vec%0d_sum", t), 32'(s), 32'(vecs[t].exp_sum));
        end

        // Reset after the 6th byte of a two-word load.
        bq.delete();
        for (int i = 0; i < 8; i++) bq.push_back(8'(8'h30 + i));
        run_load(12'h200, 2, bq, 0, 1'b0, 6, w0, s);
        chk("abort_word0", w0, 32'h3332_3130);

        bq.delete();
        b = vecs[0].seed;
        for (int i = 0; i < 4; i++) begin
            bq.push_back(b);
            b = b + vecs[0].step;
        end
        run_load(vecs[0].base, 1, bq, 0, 1'b0, 1 << 30, w0, s);
        chk("post_abort_word0", w0, vecs[0].exp_w0);

        for (int r = 0; r < 10; r++) begin
            cnt = $urandom_range(0, 4);
            rb  = (r % 3 == 0) ? 12'(12'hFFD + $urandom_range(0, 2)) : 12'($urandom);
            bq.delete();
            for (int i = 0; i < 4 * cnt; i++) bq.push_back(8'($urandom));
            run_load(rb, cnt, bq, 2, 1'($urandom_range(0, 1)), 1 << 30, w0, s);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
